dota_dac: RTL and testbench

Digital-to-analog return path for the DIGI_OTA design. It accepts parallel sample codes over a valid/ready handshake and buffers one sample ahead. At a programmable sample rate it loads each code into an active register, and it drives a single 1-bit output pin with either a first-order delta-sigma bitstream or a PWM waveform. An external RC filter turns that pin into an analog level. The inverter OTA front end turns an analog difference into a bit; this block is the opposite direction, turning codes into a bit density.

---
 rtl/dota_dac.sv | 107 ++++++++++
 tb/tb_dota_dac.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dota_dac.sv
// dota_dac: digital-to-analog return path.
// Accepts sample codes over a valid/ready handshake into a one-deep pending
// buffer. Every div+1 enabled cycles a frame ends and the pending code moves
// into the active register `cur`. The active code drives a single-bit output
// as either a first-order delta-sigma bitstream (mode=0) or a PWM waveform
// with period 2^WIDTH (mode=1). An external RC filter recovers the level.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   en           modulator enable
//   mode         0 = delta-sigma, 1 = PWM
//   div          frame length minus one (in enabled cycles)
//   in_data      sample code
//   in_valid     in_data valid
//   in_ready     pending buffer empty (registered state only)
//   dout         registered modulated bit
//   sample_tick  pulse on the frame-end cycle
//   underrun     pulse on a frame end that found the buffer empty
module dota_dac #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             sample_tick,
  output logic             underrun
);

  logic             pend_full;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] pwm_cnt;
  logic [DIV_W-1:0] frame_cnt;
  logic             mode_q;

  logic             frame_end;
  logic             accept;
  logic [WIDTH:0]   sum;

  // The >= compare lets a mid-frame decrease of div end the frame at once
  // instead of waiting for frame_cnt to wrap.
  assign frame_end   = !rst && en && (frame_cnt >= div);
  assign sample_tick = frame_end;
  assign underrun    = frame_end && !pend_full;
  assign in_ready    = !pend_full;
  assign accept      = in_valid && !pend_full;

  // Delta-sigma: the carry out of the accumulator is the output bit.
  assign sum = {1'b0, acc} + {1'b0, cur};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend      <= '0;
      cur       <= '0;
      acc       <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      mode_q    <= 1'b0;
      dout      <= 1'b0;
    end else begin
      mode_q <= mode;

      // Buffer: accept only when empty, load only when full, so the two
      // never collide. An accept on an empty-buffer frame end simply fills
      // pend; that frame end still reports underrun.
      if (accept) begin
        pend      <= in_data;
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        cur       <= pend;
        pend_full <= 1'b0;
      end

      if (!en) begin
        dout      <= 1'b0;
        acc       <= '0;
        pwm_cnt   <= '0;
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
        if (mode != mode_q) begin
          // Restart the modulator cleanly when the encoding changes.
          acc     <= '0;
          pwm_cnt <= '0;
          dout    <= 1'b0;
        end else if (!mode) begin
          dout <= sum[WIDTH];
          acc  <= sum[WIDTH-1:0];
        end else begin
          dout    <= (pwm_cnt < cur);
          pwm_cnt <= pwm_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dota_dac.sv
// Testbench for dota_dac: scoreboard of accepted codes checked against the
// active register at each load, plus density/PWM/timing checks on dout.
module tb_dota_dac;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             sample_tick;
  logic             underrun;

  dota_dac #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .div        (div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .sample_tick(sample_tick),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: accepted codes queue up and must appear in cur in order.
  int unsigned sb[$];
  int  exp_cur     = 0;
  bit  cur_pending = 0;
  bit  load_prev   = 0;
  int  ur_count    = 0;
  int  load_count  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cur_pending) begin
        check("cur_load", int'(dut.cur), exp_cur);
        cur_pending = 0;
      end
      if (load_prev) check("rdy_rise", int'(in_ready), 1);
      load_prev = 0;
      if (in_valid && in_ready) begin
        sb.push_back(int'(in_data));
        $display("accept code=%0d t=%0t", in_data, $time);
      end
      if (sample_tick && underrun) ur_count++;
      if (sample_tick && !underrun) begin
        check("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_cur     = int'(sb.pop_front());
          cur_pending = 1;
        end
        load_count++;
        load_prev = 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_code(input int code);
    int found;
    found = 0;
    @(posedge clk); #1;
    in_data  = code[WIDTH-1:0];
    in_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1;
        break;
      end
    end
    check("send_rdy", found, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_load();
    int found;
    found = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (sample_tick && !underrun) begin
        found = 1;
        break;
      end
    end
    check("load_seen", found, 1);
  endtask

  // Counts dout ones over n cycles; gap>0 also counts spacing violations.
  task automatic count_ones(input int n, input int gap, output int ones, output int gap_bad);
    int last;
    ones = 0; gap_bad = 0; last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dout) begin
        ones++;
        if (gap > 0 && last >= 0 && (i - last) != gap) gap_bad++;
        last = i;
      end
    end
  endtask

  initial begin
    int ones, gbad, found, ur0, ld0, a, s, e, changes;
    int smp[257];
    int codes[4];
    codes[0] = 10; codes[1] = 20; codes[2] = 30; codes[3] = 40;

    rst = 1'b1; en = 1'b0; mode = 1'b0; div = 8'd3;
    in_data = '0; in_valid = 1'b0;

    // Reset
    repeat (3) begin
      @(negedge clk);
      check("rst_dout", int'(dout), 0);
      check("rst_rdy", int'(in_ready), 1);
      check("rst_tick", int'(sample_tick), 0);
      check("rst_ur", int'(underrun), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_dout", int'(dout), 0);
    check("post_rst_rdy", int'(in_ready), 1);
    @(posedge clk); #1;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("first_tick", int'(sample_tick), int'(i == 4));
      check("first_ur", int'(underrun), int'(i == 4));
    end
    $display("reset/first frame checked");

    // Delta-sigma densities
    @(posedge clk); #1;
    div = 8'd255; mode = 1'b0;
    send_code(64);
    wait_load();
    @(negedge clk);
    count_ones(256, 4, ones, gbad);
    check("ds64_ones", ones, 64);
    check("ds64_gap", gbad, 0);
    $display("ds code=64 ones=%0d", ones);

    send_code(0);
    wait_load();
    @(negedge clk);
    count_ones(256, 0, ones, gbad);
    check("ds0_ones", ones, 0);
    $display("ds code=0 ones=%0d", ones);

    send_code(255);
    wait_load();
    @(negedge clk);
    count_ones(256, 0, ones, gbad);
    check("ds255_ones", ones, 255);
    $display("ds code=255 ones=%0d", ones);

    // PWM
    @(posedge clk); #1;
    mode = 1'b1;
    send_code(100);
    wait_load();
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      smp[i] = int'(dout);
    end
    ones = 0; changes = 0;
    for (int i = 0; i < 256; i++) begin
      ones += smp[i];
      if (smp[i] != smp[i+1]) changes++;
    end
    check("pwm_ones", ones, 100);
    check("pwm_edges", changes, 2);
    $display("pwm code=100 ones=%0d edges=%0d", ones, changes);

    // Backpressure streaming
    @(posedge clk); #1;
    div = 8'd7;
    in_data = codes[0][WIDTH-1:0];
    in_valid = 1'b1;
    ur0 = 0;
    ld0 = load_count;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (in_ready) begin
          found = 1;
          break;
        end
      end
      check("stream_rdy", found, 1);
      @(posedge clk); #1;
      if (k == 0) ur0 = ur_count;
      if (k < 3) in_data = codes[k+1][WIDTH-1:0];
      else in_valid = 1'b0;
      @(negedge clk);
      check("rdy_drop", int'(in_ready), 0);
    end
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (load_count - ld0 >= 4) break;
    end
    check("stream_loads", load_count - ld0, 4);
    check("stream_ur", ur_count - ur0, 0);
    $display("stream loads=%0d underruns=%0d", load_count - ld0, ur_count - ur0);

    // Underrun with coincident accept
    #1;
    div = 8'd3;
    found = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sample_tick) begin
        found = 1;
        break;
      end
    end
    check("co_wait_tick", found, 1);
    repeat (4) @(posedge clk);
    #1;
    in_data = 8'd77; in_valid = 1'b1;
    @(negedge clk);
    check("co_tick", int'(sample_tick), 1);
    check("co_ur", int'(underrun), 1);
    check("co_rdy", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("co2_tick", int'(sample_tick), 1);
    check("co2_ur", int'(underrun), 0);
    $display("coincident accept code=77 checked");

    // Disable mid-frame while dout is high
    found = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (dout) begin
        found = 1;
        break;
      end
    end
    check("dis_wait_high", found, 1);
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("dis_tick", int'(sample_tick), 0);
    @(negedge clk);
    check("dis_dout", int'(dout), 0);
    repeat (3) begin
      @(negedge clk);
      check("dis_idle_tick", int'(sample_tick), 0);
      check("dis_idle_dout", int'(dout), 0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("re_tick", int'(sample_tick), int'(i == 4));
    end
    $display("disable/re-enable checked");

    // Mode switch PWM -> delta-sigma: acc restarts from 0
    @(posedge clk); #1;
    mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sw_ds_dout", int'(dout), 0);
    a = 0;
    for (int k = 0; k < 16; k++) begin
      s = a + 77;
      e = s >> 8;
      a = s & 255;
      @(negedge clk);
      check("ds_seq", int'(dout), e);
    end
    $display("mode switch to delta-sigma checked");

    // Mode switch delta-sigma -> PWM: pwm_cnt restarts from 0
    @(posedge clk); #1;
    mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sw_pwm_dout", int'(dout), 0);
    for (int k = 0; k < 78; k++) begin
      @(negedge clk);
      check("pwm_restart", int'(dout), int'(k < 77));
    end
    $display("mode switch to pwm checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
